// File: rtl/ar_remap_pkg.sv
// Shared AR-channel types for the ID remapper: burst encodings and the request payload.
package ar_remap_pkg;

  // The payload is sized for the widest supported address/length; narrower instances zero-extend.
  localparam int unsigned AR_ADDR_MAX = 64;
  localparam int unsigned AR_LEN_MAX  = 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef struct packed {
    logic [AR_ADDR_MAX-1:0] addr;
    logic [AR_LEN_MAX-1:0]  len;
    logic [2:0]             size;
    logic [1:0]             burst;
    logic [3:0]             qos;
  } ar_req_t;

  function automatic logic burst_legal(input logic [1:0] b);
    return (b == BURST_FIXED) || (b == BURST_INCR) || (b == BURST_WRAP);
  endfunction

endpackage

// File: rtl/tag_free_list.sv
// Tag pool: busy vector, lowest-free-index allocator, release port and busy count.
module tag_free_list #(
  parameter  int unsigned NUM_TAGS  = 8,
  localparam int unsigned TAG_WIDTH = $clog2(NUM_TAGS),
  localparam int unsigned CNT_WIDTH = $clog2(NUM_TAGS) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc,
  input  logic                 rel_valid,
  input  logic [TAG_WIDTH-1:0] rel_tag,
  output logic                 any_free,
  output logic [TAG_WIDTH-1:0] free_tag,
  output logic                 rel_hit,
  output logic [CNT_WIDTH-1:0] count
);

  logic [NUM_TAGS-1:0] busy;

  assign any_free = ~&busy;
  assign rel_hit  = rel_valid && busy[rel_tag];

  // Scan downward so the lowest free index wins.
  always_comb begin
    free_tag = '0;
    for (int i = int'(NUM_TAGS) - 1; i >= 0; i--) begin
      if (!busy[i]) free_tag = TAG_WIDTH'(i);
    end
  end

  // alloc and release never target the same tag: the allocator only picks tags idle this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= '0;
      count <= '0;
    end else begin
      if (alloc)   busy[free_tag] <= 1'b1;
      if (rel_hit) busy[rel_tag]  <= 1'b0;
      case ({alloc, rel_hit})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ar_id_remap.sv
// AR ID remapper: swaps the upstream AXI ID for a pool tag and remembers the original ID per tag.
module ar_id_remap
  import ar_remap_pkg::*;
#(
  parameter  int unsigned ID_WIDTH   = 4,
  parameter  int unsigned ADDR_WIDTH = 32,
  parameter  int unsigned LEN_WIDTH  = 8,
  parameter  int unsigned NUM_TAGS   = 8,
  localparam int unsigned TAG_WIDTH  = $clog2(NUM_TAGS),
  localparam int unsigned CNT_WIDTH  = $clog2(NUM_TAGS) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  up_valid,
  input  logic [ID_WIDTH-1:0]   up_id,
  input  logic [ADDR_WIDTH-1:0] up_addr,
  input  logic [LEN_WIDTH-1:0]  up_len,
  input  logic [2:0]            up_size,
  input  logic [1:0]            up_burst,
  input  logic [3:0]            up_qos,
  output logic                  up_ready,
  output logic                  dn_valid,
  output logic [TAG_WIDTH-1:0]  dn_id,
  output logic [ADDR_WIDTH-1:0] dn_addr,
  output logic [LEN_WIDTH-1:0]  dn_len,
  output logic [2:0]            dn_size,
  output logic [1:0]            dn_burst,
  output logic [3:0]            dn_qos,
  input  logic                  dn_ready,
  input  logic                  rel_valid,
  input  logic [TAG_WIDTH-1:0]  rel_tag,
  output logic [ID_WIDTH-1:0]   rel_orig_id,
  output logic                  rel_err,
  output logic [CNT_WIDTH-1:0]  outstanding
);

  logic                 any_free;
  logic [TAG_WIDTH-1:0] free_tag;
  logic                 rel_hit;
  logic                 accept;
  ar_req_t              up_req;
  ar_req_t              dn_req;
  logic [ID_WIDTH-1:0]  id_table [NUM_TAGS];

  tag_free_list #(
    .NUM_TAGS (NUM_TAGS)
  ) u_free_list (
    .clk       (clk),
    .rst       (rst),
    .alloc     (accept),
    .rel_valid (rel_valid),
    .rel_tag   (rel_tag),
    .any_free  (any_free),
    .free_tag  (free_tag),
    .rel_hit   (rel_hit),
    .count     (outstanding)
  );

  // Ready looks only at pool state and the output slot, never at up_valid.
  assign up_ready = !rst && any_free && (!dn_valid || dn_ready);
  assign accept   = up_valid && up_ready;

  always_comb begin
    up_req       = '0;
    up_req.addr  = AR_ADDR_MAX'(up_addr);
    up_req.len   = AR_LEN_MAX'(up_len);
    up_req.size  = up_size;
    up_req.burst = up_burst;
    up_req.qos   = up_qos;
  end

  // Output slot: loads on accept, holds while stalled, drops valid after a bare handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      dn_valid <= 1'b0;
      dn_id    <= '0;
      dn_req   <= '0;
      rel_err  <= 1'b0;
    end else begin
      rel_err <= rel_valid && !rel_hit;
      if (accept) begin
        dn_valid <= 1'b1;
        dn_id    <= free_tag;
        dn_req   <= up_req;
      end else if (dn_ready) begin
        dn_valid <= 1'b0;
      end
    end
  end

  // Entries are left stale on release; only the busy vector says which are live.
  always_ff @(posedge clk) begin
    if (accept) id_table[free_tag] <= up_id;
  end

  assign rel_orig_id = id_table[rel_tag];

  assign dn_addr  = ADDR_WIDTH'(dn_req.addr);
  assign dn_len   = LEN_WIDTH'(dn_req.len);
  assign dn_size  = dn_req.size;
  assign dn_burst = dn_req.burst;
  assign dn_qos   = dn_req.qos;

endmodule

// File: tb/tb_ar_id_remap.sv
// Directed bench for ar_id_remap: per-cycle vector table plus a hand-written stall/field-hold sequence.
module tb_ar_id_remap;
  import ar_remap_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        up_valid;
  logic [3:0]  up_id;
  logic [31:0] up_addr;
  logic [7:0]  up_len;
  logic [2:0]  up_size;
  logic [1:0]  up_burst;
  logic [3:0]  up_qos;
  logic        up_ready;
  logic        dn_valid;
  logic [2:0]  dn_id;
  logic [31:0] dn_addr;
  logic [7:0]  dn_len;
  logic [2:0]  dn_size;
  logic [1:0]  dn_burst;
  logic [3:0]  dn_qos;
  logic        dn_ready;
  logic        rel_valid;
  logic [2:0]  rel_tag;
  logic [3:0]  rel_orig_id;
  logic        rel_err;
  logic [3:0]  outstanding;

  int n_cmp = 0;
  int n_err = 0;

  ar_id_remap dut (
    .clk         (clk),
    .rst         (rst),
    .up_valid    (up_valid),
    .up_id       (up_id),
    .up_addr     (up_addr),
    .up_len      (up_len),
    .up_size     (up_size),
    .up_burst    (up_burst),
    .up_qos      (up_qos),
    .up_ready    (up_ready),
    .dn_valid    (dn_valid),
    .dn_id       (dn_id),
    .dn_addr     (dn_addr),
    .dn_len      (dn_len),
    .dn_size     (dn_size),
    .dn_burst    (dn_burst),
    .dn_qos      (dn_qos),
    .dn_ready    (dn_ready),
    .rel_valid   (rel_valid),
    .rel_tag     (rel_tag),
    .rel_orig_id (rel_orig_id),
    .rel_err     (rel_err),
    .outstanding (outstanding)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        uv;
    logic [3:0]  uid;
    logic [31:0] uaddr;
    logic        dr;
    logic        rv;
    logic [2:0]  rtag;
    logic        e_rdy;
    logic        e_dv;
    logic [2:0]  e_id;
    logic [31:0] e_addr;
    logic [3:0]  e_out;
    logic        e_err;
    logic [3:0]  e_rid;
  } vec_t;

  vec_t vecs [30];

  function automatic vec_t mk(input logic r, input logic uv, input logic [3:0] uid,
                              input logic [31:0] ua, input logic dr, input logic rv,
                              input logic [2:0] rt, input logic er, input logic edv,
                              input logic [2:0] eid, input logic [31:0] ea,
                              input logic [3:0] eo, input logic ee, input logic [3:0] erid);
    vec_t v;
    v.rst = r;  v.uv = uv;  v.uid = uid;  v.uaddr = ua;  v.dr = dr;
    v.rv = rv;  v.rtag = rt;  v.e_rdy = er;  v.e_dv = edv;  v.e_id = eid;
    v.e_addr = ea;  v.e_out = eo;  v.e_err = ee;  v.e_rid = erid;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic v, input logic [3:0] id, input logic [31:0] a);
    up_valid = v;
    up_id    = id;
    up_addr  = a;
  endtask

  initial begin
    // Columns: rst uv uid uaddr dr rv rtag | up_ready dn_valid dn_id dn_addr outstanding rel_err rel_orig_id
    vecs[0]  = mk(1, 0, 4'h0, 32'h0,    1, 0, 3'd0, 0, 0, 3'd0, 32'h0,    4'd0, 0, 4'h0);
    vecs[1]  = mk(0, 1, 4'hA, 32'h1000, 1, 0, 3'd0, 1, 0, 3'd0, 32'h0,    4'd0, 0, 4'h0);
    vecs[2]  = mk(0, 0, 4'h0, 32'h0,    1, 0, 3'd0, 1, 1, 3'd0, 32'h1000, 4'd1, 0, 4'h0);
    vecs[3]  = mk(0, 0, 4'h0, 32'h0,    1, 0, 3'd0, 1, 0, 3'd0, 32'h1000, 4'd1, 0, 4'h0);
    for (int k = 1; k <= 7; k++)
      vecs[3+k] = mk(0, 1, 4'(k), 32'h1000 + 32'(k) * 32'h100, 1, 0, 3'd0,
                     1, (k != 1), 3'(k-1), 32'h1000 + 32'(k-1) * 32'h100, 4'(k), 0, 4'h0);
    vecs[11] = mk(0, 1, 4'h9, 32'h9000, 1, 0, 3'd0, 0, 1, 3'd7, 32'h1700, 4'd8, 0, 4'h0);
    vecs[12] = mk(0, 1, 4'h9, 32'h9000, 1, 1, 3'd5, 0, 0, 3'd7, 32'h1700, 4'd8, 0, 4'h5);
    vecs[13] = mk(0, 1, 4'h9, 32'h9000, 1, 0, 3'd0, 1, 0, 3'd7, 32'h1700, 4'd7, 0, 4'h0);
    vecs[14] = mk(0, 1, 4'hB, 32'hB000, 0, 1, 3'd0, 0, 1, 3'd5, 32'h9000, 4'd8, 0, 4'hA);
    vecs[15] = mk(0, 1, 4'hB, 32'hB000, 0, 0, 3'd0, 0, 1, 3'd5, 32'h9000, 4'd7, 0, 4'h0);
    vecs[16] = mk(0, 1, 4'hB, 32'hB000, 0, 0, 3'd0, 0, 1, 3'd5, 32'h9000, 4'd7, 0, 4'h0);
    vecs[17] = mk(0, 1, 4'hB, 32'hB000, 0, 0, 3'd0, 0, 1, 3'd5, 32'h9000, 4'd7, 0, 4'h0);
    vecs[18] = mk(0, 1, 4'hB, 32'hB000, 1, 0, 3'd0, 1, 1, 3'd5, 32'h9000, 4'd7, 0, 4'h0);
    vecs[19] = mk(0, 0, 4'h0, 32'h0,    1, 1, 3'd7, 0, 1, 3'd0, 32'hB000, 4'd8, 0, 4'h7);
    vecs[20] = mk(0, 0, 4'h0, 32'h0,    1, 0, 3'd0, 1, 0, 3'd0, 32'hB000, 4'd7, 0, 4'h0);
    vecs[21] = mk(0, 1, 4'hC, 32'hC000, 1, 1, 3'd2, 1, 0, 3'd0, 32'hB000, 4'd7, 0, 4'h2);
    vecs[22] = mk(0, 1, 4'hD, 32'hD000, 1, 0, 3'd0, 1, 1, 3'd7, 32'hC000, 4'd7, 0, 4'h0);
    vecs[23] = mk(0, 0, 4'h0, 32'h0,    1, 1, 3'd3, 0, 1, 3'd2, 32'hD000, 4'd8, 0, 4'h3);
    vecs[24] = mk(0, 0, 4'h0, 32'h0,    1, 1, 3'd3, 1, 0, 3'd2, 32'hD000, 4'd7, 0, 4'h3);
    vecs[25] = mk(0, 0, 4'h0, 32'h0,    1, 0, 3'd0, 1, 0, 3'd2, 32'hD000, 4'd7, 1, 4'h0);
    vecs[26] = mk(0, 1, 4'hE, 32'hE000, 0, 0, 3'd0, 1, 0, 3'd2, 32'hD000, 4'd7, 0, 4'h0);
    vecs[27] = mk(1, 0, 4'h0, 32'h0,    0, 0, 3'd0, 0, 1, 3'd3, 32'hE000, 4'd8, 0, 4'h0);
    vecs[28] = mk(0, 1, 4'hF, 32'hF000, 1, 0, 3'd0, 1, 0, 3'd0, 32'h0,    4'd0, 0, 4'h0);
    vecs[29] = mk(0, 0, 4'h0, 32'h0,    1, 0, 3'd0, 1, 1, 3'd0, 32'hF000, 4'd1, 0, 4'h0);

    rst = 1'b1;
    drive_req(1'b0, 4'h0, 32'h0);
    up_len = 8'd3;  up_size = 3'd2;  up_burst = BURST_INCR;  up_qos = 4'h0;
    dn_ready = 1'b1;  rel_valid = 1'b0;  rel_tag = 3'd0;
    repeat (2) @(negedge clk);

    // Inputs change on the falling edge; outputs are sampled 1 time unit later, well clear of the rising edge.
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      rst       = vecs[i].rst;
      drive_req(vecs[i].uv, vecs[i].uid, vecs[i].uaddr);
      dn_ready  = vecs[i].dr;
      rel_valid = vecs[i].rv;
      rel_tag   = vecs[i].rtag;
      #1;
      check($sformatf("r%0d up_ready", i),    64'(up_ready),    64'(vecs[i].e_rdy));
      check($sformatf("r%0d dn_valid", i),    64'(dn_valid),    64'(vecs[i].e_dv));
      check($sformatf("r%0d dn_id", i),       64'(dn_id),       64'(vecs[i].e_id));
      check($sformatf("r%0d dn_addr", i),     64'(dn_addr),     64'(vecs[i].e_addr));
      check($sformatf("r%0d outstanding", i), 64'(outstanding), 64'(vecs[i].e_out));
      check($sformatf("r%0d rel_err", i),     64'(rel_err),     64'(vecs[i].e_err));
      if (vecs[i].rv)
        check($sformatf("r%0d rel_orig_id", i), 64'(rel_orig_id), 64'(vecs[i].e_rid));
    end

    // Reset with a live request, then a stalled request whose every field must hold.
    @(negedge clk);
    rst = 1'b1;  drive_req(1'b0, 4'h0, 32'h0);  dn_ready = 1'b0;  rel_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    drive_req(1'b1, 4'h2, 32'h4444);
    up_len = 8'h7F;  up_size = 3'd5;  up_burst = BURST_WRAP;  up_qos = 4'hC;
    #1;
    check("hs post-reset outstanding", 64'(outstanding), 64'd0);
    check("hs post-reset up_ready", 64'(up_ready), 64'd1);
    @(negedge clk);
    drive_req(1'b1, 4'h6, 32'h5555);
    up_len = 8'h01;  up_size = 3'd1;  up_burst = BURST_FIXED;  up_qos = 4'h3;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("hs stall%0d dn_valid", c), 64'(dn_valid), 64'd1);
      check($sformatf("hs stall%0d dn_id", c),    64'(dn_id),    64'd0);
      check($sformatf("hs stall%0d dn_addr", c),  64'(dn_addr),  64'h4444);
      check($sformatf("hs stall%0d dn_len", c),   64'(dn_len),   64'h7F);
      check($sformatf("hs stall%0d dn_size", c),  64'(dn_size),  64'd5);
      check($sformatf("hs stall%0d dn_burst", c), 64'(dn_burst), 64'(BURST_WRAP));
      check($sformatf("hs stall%0d dn_qos", c),   64'(dn_qos),   64'hC);
      check($sformatf("hs stall%0d up_ready", c), 64'(up_ready), 64'd0);
      check($sformatf("hs stall%0d burst_ok", c), 64'(burst_legal(dn_burst)), 64'd1);
      @(negedge clk);
    end
    dn_ready = 1'b1;
    #1;
    check("hs release-stall up_ready", 64'(up_ready), 64'd1);
    @(negedge clk);
    drive_req(1'b0, 4'h0, 32'h0);
    rel_valid = 1'b1;  rel_tag = 3'd0;
    #1;
    check("hs next dn_valid",    64'(dn_valid),    64'd1);
    check("hs next dn_id",       64'(dn_id),       64'd1);
    check("hs next dn_addr",     64'(dn_addr),     64'h5555);
    check("hs next dn_len",      64'(dn_len),      64'h01);
    check("hs next dn_qos",      64'(dn_qos),      64'h3);
    check("hs next outstanding", 64'(outstanding), 64'd2);
    check("hs rel_orig_id",      64'(rel_orig_id), 64'h2);
    @(negedge clk);
    rel_valid = 1'b0;
    #1;
    check("hs after rel outstanding", 64'(outstanding), 64'd1);
    check("hs after rel rel_err",     64'(rel_err),     64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
